// File: rtl/sweep_scheduler_pkg.sv
// Shared definitions for the fast-square sweep sequencer: state encoding,
// settings-bus register offsets and CTRL bit positions.
package sweep_scheduler_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_RST    = 3'd1,
    S_SETTLE = 3'd2,
    S_RECORD = 3'd3,
    S_NEXT   = 3'd4,
    S_STEP   = 3'd5,
    S_DONE   = 3'd6
  } state_t;

  localparam logic [1:0] OFF_CTRL   = 2'd0;
  localparam logic [1:0] OFF_STEPS  = 2'd1;
  localparam logic [1:0] OFF_SETTLE = 2'd2;
  localparam logic [1:0] OFF_RECORD = 2'd3;

  localparam int CTRL_EN   = 0;
  localparam int CTRL_CONT = 1;

  // Zero-length windows are meaningless; treat 0 as 1.
  function automatic logic [15:0] clamp1(input logic [15:0] v);
    return (v == 16'd0) ? 16'd1 : v;
  endfunction

endpackage

// File: rtl/sweep_regs.sv
// Settings-bus decode and the four sweep configuration registers
// (CTRL, STEPS, SETTLE, RECORD) starting at BASE_ADDR.
module sweep_regs
  import sweep_scheduler_pkg::*;
#(
  parameter logic [6:0] BASE_ADDR      = 7'd64,
  parameter int         MAX_STEPS_LOG2 = 6
) (
  input  logic                      clk64,
  input  logic                      reset_n,
  input  logic                      serial_strobe,
  input  logic [6:0]                serial_addr,
  input  logic [31:0]               serial_data,
  output logic                      enable,
  output logic                      continuous,
  output logic [MAX_STEPS_LOG2-1:0] num_steps,
  output logic [15:0]               settle_ticks,
  output logic [15:0]               record_ticks
);

  logic [6:0] off;
  logic       hit;
  logic       unused_data;

  assign off         = serial_addr - BASE_ADDR;
  assign hit         = serial_strobe && (off[6:2] == 5'd0);
  assign unused_data = ^serial_data[31:16];

  always_ff @(posedge clk64 or negedge reset_n) begin
    if (!reset_n) begin
      enable       <= 1'b0;
      continuous   <= 1'b0;
      num_steps    <= '0;
      settle_ticks <= 16'd0;
      record_ticks <= 16'd0;
    end else if (hit) begin
      case (off[1:0])
        OFF_CTRL: begin
          enable     <= serial_data[CTRL_EN];
          continuous <= serial_data[CTRL_CONT];
        end
        OFF_STEPS:  num_steps    <= serial_data[MAX_STEPS_LOG2-1:0];
        OFF_SETTLE: settle_ticks <= serial_data[15:0];
        OFF_RECORD: record_ticks <= serial_data[15:0];
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/sweep_scheduler.sv
// Frequency-sweep sequencer: steps the synthesizer and strobes reset/record/
// next into the fast_square_bb instances, one settle+record window per step.
module sweep_scheduler
  import sweep_scheduler_pkg::*;
#(
  parameter logic [6:0] BASE_ADDR      = 7'd64,
  parameter int         STEP_PULSE     = 4,
  parameter int         MAX_STEPS_LOG2 = 6
) (
  input  logic                      clk64,
  input  logic                      reset_n,
  input  logic                      serial_strobe,
  input  logic [6:0]                serial_addr,
  input  logic [31:0]               serial_data,
  input  logic                      arm,
  input  logic                      sweep_restart,
  output logic                      freq_step,
  output logic                      rx_reset,
  output logic                      rx_record,
  output logic                      rx_next,
  output logic [MAX_STEPS_LOG2-1:0] step_index,
  output logic                      sweep_done,
  output logic                      busy
);

  logic                      enable, continuous;
  logic [MAX_STEPS_LOG2-1:0] num_steps;
  logic [15:0]               settle_ticks, record_ticks;

  sweep_regs #(
    .BASE_ADDR      (BASE_ADDR),
    .MAX_STEPS_LOG2 (MAX_STEPS_LOG2)
  ) u_regs (
    .clk64         (clk64),
    .reset_n       (reset_n),
    .serial_strobe (serial_strobe),
    .serial_addr   (serial_addr),
    .serial_data   (serial_data),
    .enable        (enable),
    .continuous    (continuous),
    .num_steps     (num_steps),
    .settle_ticks  (settle_ticks),
    .record_ticks  (record_ticks)
  );

  state_t                    state, nxt;
  logic [15:0]               cnt;
  logic [MAX_STEPS_LOG2-1:0] sh_steps, last_idx;
  logic [15:0]               sh_settle, sh_record;
  logic                      last_step;

  // num_steps of 0 runs a single step, so its last index is also 0.
  assign last_idx  = (sh_steps == '0) ? '0 : sh_steps - 1'b1;
  assign last_step = (step_index == last_idx);

  always_comb begin
    nxt = state;
    if (state != S_IDLE && !enable)             nxt = S_IDLE;
    else if (state != S_IDLE && sweep_restart)  nxt = S_RST;
    else begin
      case (state)
        S_IDLE:   if (enable && arm) nxt = S_RST;
        S_RST:    nxt = S_SETTLE;
        S_SETTLE: if (cnt == 16'd0) nxt = S_RECORD;
        S_RECORD: if (cnt == 16'd0) nxt = S_NEXT;
        S_NEXT:   nxt = last_step ? S_DONE : S_STEP;
        S_STEP:   if (cnt == 16'd0) nxt = S_SETTLE;
        S_DONE:   nxt = continuous ? S_RST : S_IDLE;
        default:  nxt = S_IDLE;
      endcase
    end
  end

  // Strobes are registered from the next state, so each one is high exactly
  // for the cycles the FSM spends in its state.
  always_ff @(posedge clk64 or negedge reset_n) begin
    if (!reset_n) begin
      state      <= S_IDLE;
      cnt        <= 16'd0;
      sh_steps   <= '0;
      sh_settle  <= 16'd0;
      sh_record  <= 16'd0;
      step_index <= '0;
      freq_step  <= 1'b0;
      rx_reset   <= 1'b0;
      rx_record  <= 1'b0;
      rx_next    <= 1'b0;
      sweep_done <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= nxt;
      rx_reset   <= (nxt == S_RST);
      rx_record  <= (nxt == S_RECORD);
      rx_next    <= (nxt == S_NEXT);
      freq_step  <= (nxt == S_STEP);
      sweep_done <= (nxt == S_DONE);
      busy       <= (nxt != S_IDLE);
      case (nxt)
        S_RST: begin
          step_index <= '0;
          sh_steps   <= num_steps;
          sh_settle  <= settle_ticks;
          sh_record  <= record_ticks;
          cnt        <= settle_ticks;
        end
        S_SETTLE:
          cnt <= (state == S_SETTLE) ? cnt - 16'd1 : sh_settle;
        S_RECORD:
          cnt <= (state == S_RECORD) ? cnt - 16'd1 : clamp1(sh_record) - 16'd1;
        S_STEP: begin
          cnt <= (state == S_STEP) ? cnt - 16'd1 : 16'(STEP_PULSE - 1);
          if (state == S_NEXT) step_index <= step_index + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sweep_scheduler.sv
// Scoreboard bench: stimulus pushes expected strobe pulses (kind, width,
// quiet cycles before it, step index); a monitor reconstructs pulses and pops.
module tb_sweep_scheduler;

  localparam int K_RST = 1, K_REC = 2, K_NXT = 4, K_STP = 8, K_DONE = 16;

  typedef struct {
    int kind;
    int len;
    int gap;   // -1 = don't care
    int idx;
  } ev_t;

  logic        clk64, reset_n, serial_strobe, arm, sweep_restart;
  logic [6:0]  serial_addr;
  logic [31:0] serial_data;
  logic        freq_step, rx_reset, rx_record, rx_next, sweep_done, busy;
  logic [5:0]  step_index;

  int  total = 0, bad = 0;
  ev_t exp_q[$];

  sweep_scheduler dut (
    .clk64         (clk64),
    .reset_n       (reset_n),
    .serial_strobe (serial_strobe),
    .serial_addr   (serial_addr),
    .serial_data   (serial_data),
    .arm           (arm),
    .sweep_restart (sweep_restart),
    .freq_step     (freq_step),
    .rx_reset      (rx_reset),
    .rx_record     (rx_record),
    .rx_next       (rx_next),
    .step_index    (step_index),
    .sweep_done    (sweep_done),
    .busy          (busy)
  );

  initial clk64 = 1'b0;
  always #5 clk64 = ~clk64;

  task automatic check(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  task automatic push(input int kind, input int len, input int gap, input int idx);
    ev_t e;
    e.kind = kind; e.len = len; e.gap = gap; e.idx = idx;
    exp_q.push_back(e);
  endtask

  task automatic push_sweep(input int n, input int s, input int r, input int rgap);
    push(K_RST, 1, rgap, 0);
    for (int i = 0; i < n; i++) begin
      push(K_REC, r, s + 1, i);
      push(K_NXT, 1, 0, i);
      if (i < n - 1) push(K_STP, 4, 0, i + 1);
      else           push(K_DONE, 1, 0, i);
    end
  endtask

  task automatic wr(input logic [1:0] off, input logic [31:0] d);
    @(posedge clk64); #1;
    serial_strobe = 1'b1;
    serial_addr   = 7'd64 + 7'(off);
    serial_data   = d;
    @(posedge clk64); #1;
    serial_strobe = 1'b0;
  endtask

  task automatic arm_pulse();
    @(posedge clk64); #1 arm = 1'b1;
    @(posedge clk64); #1 arm = 1'b0;
  endtask

  task automatic wait_idle(input string nm);
    int k;
    k = 0;
    @(negedge clk64);
    while (busy && k < 5000) begin
      @(negedge clk64);
      k++;
    end
    check(nm, int'(busy), 0);
  endtask

  // Monitor: rebuild strobe pulses and compare against the scoreboard.
  initial begin
    logic [4:0] prev, cur;
    int len, gap, sgap, sidx;
    ev_t e;
    prev = '0; len = 0; gap = 0; sgap = 0; sidx = 0;
    forever begin
      @(negedge clk64);
      cur = {sweep_done, freq_step, rx_next, rx_record, rx_reset};
      check("one_strobe", int'($countones(cur) <= 1), 1);
      if (cur == prev && cur != '0) len++;
      else begin
        if (prev != '0) begin
          total++;
          if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL event: unexpected kind=%0d len=%0d gap=%0d idx=%0d", prev, len, sgap, sidx);
          end else begin
            e = exp_q.pop_front();
            if (e.kind != int'(prev) || e.len != len || e.idx != sidx ||
                (e.gap >= 0 && e.gap != sgap)) begin
              bad++;
              $display("FAIL event: got kind=%0d len=%0d gap=%0d idx=%0d want kind=%0d len=%0d gap=%0d idx=%0d",
                       prev, len, sgap, sidx, e.kind, e.len, e.gap, e.idx);
            end
          end
        end
        if (cur != '0) begin
          len = 1; sgap = gap; sidx = int'(step_index); gap = 0;
        end
      end
      if (cur == '0) gap++;
      prev = cur;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    reset_n = 1'b0; serial_strobe = 1'b0; serial_addr = '0; serial_data = '0;
    arm = 1'b0; sweep_restart = 1'b0;
    #12;
    check("rst_busy", int'(busy), 0);
    check("rst_step_index", int'(step_index), 0);
    check("rst_strobes", int'({sweep_done, freq_step, rx_next, rx_record, rx_reset}), 0);
    @(posedge clk64); #3 reset_n = 1'b1;

    // 1: 3 steps, settle 10, record 20
    wr(2'd1, 3); wr(2'd2, 10); wr(2'd3, 20); wr(2'd0, 1);
    push_sweep(3, 10, 20, -1);
    arm_pulse();
    wait_idle("t1_idle");
    check("t1_step_index", int'(step_index), 2);

    // 2: all-zero geometry clamps to one step, one record cycle
    wr(2'd1, 0); wr(2'd2, 0); wr(2'd3, 0);
    push_sweep(1, 0, 1, -1);
    arm_pulse();
    wait_idle("t2_idle");

    // 3: continuous; second sweep aborted mid-RECORD of step 1
    wr(2'd1, 2); wr(2'd2, 2); wr(2'd3, 5); wr(2'd0, 3);
    push_sweep(2, 2, 5, -1);
    push(K_RST, 1, 0, 0); push(K_REC, 5, 3, 0); push(K_NXT, 1, 0, 0);
    push(K_STP, 4, 0, 1); push(K_REC, 3, 3, 1);
    arm_pulse();
    k = 0;
    while (!sweep_done && k < 2000) begin @(negedge clk64); k++; end
    check("t3_first_done", int'(sweep_done), 1);
    k = 0;
    while (!(rx_record && step_index == 6'd1) && k < 2000) begin @(negedge clk64); k++; end
    check("t3_record_step1", int'(rx_record), 1);
    wr(2'd0, 0);
    wait_idle("t3_abort_idle");
    check("t3_index_held", int'(step_index), 1);

    // 4: RECORD rewrite mid-sweep only affects the next sweep
    wr(2'd1, 3); wr(2'd2, 1); wr(2'd3, 20); wr(2'd0, 1);
    push_sweep(3, 1, 20, -1);
    arm_pulse();
    k = 0;
    while (!(rx_record && step_index == 6'd1) && k < 2000) begin @(negedge clk64); k++; end
    check("t4_record_step1", int'(rx_record), 1);
    wr(2'd3, 50);
    wait_idle("t4_idle_a");
    push_sweep(3, 1, 50, -1);
    arm_pulse();
    wait_idle("t4_idle_b");

    // 5: restart during STEP at step_index 5 truncates freq_step
    wr(2'd1, 8); wr(2'd2, 0); wr(2'd3, 1);
    push(K_RST, 1, -1, 0);
    for (int i = 0; i < 5; i++) begin
      push(K_REC, 1, 1, i); push(K_NXT, 1, 0, i);
      push(K_STP, (i < 4) ? 4 : 2, 0, i + 1);
    end
    push_sweep(8, 0, 1, 0);
    arm_pulse();
    k = 0;
    while (!(freq_step && step_index == 6'd5) && k < 2000) begin @(negedge clk64); k++; end
    check("t5_step5", int'(freq_step), 1);
    @(posedge clk64); #1 sweep_restart = 1'b1;
    @(posedge clk64); #1 sweep_restart = 1'b0;
    check("t5_rx_reset", int'(rx_reset), 1);
    check("t5_index_zero", int'(step_index), 0);
    wait_idle("t5_idle");

    // 6: async reset mid-RECORD clears everything without a clock edge
    wr(2'd1, 1); wr(2'd2, 0); wr(2'd3, 20);
    push(K_RST, 1, -1, 0); push(K_REC, 2, 1, 0);
    arm_pulse();
    arm = 1'b1;
    k = 0;
    while (!rx_record && k < 2000) begin @(negedge clk64); k++; end
    check("t6_record", int'(rx_record), 1);
    @(posedge clk64); #7 reset_n = 1'b0;
    #1;
    check("t6_async_record", int'(rx_record), 0);
    check("t6_async_busy", int'(busy), 0);
    @(posedge clk64); #3 reset_n = 1'b1;
    repeat (10) @(negedge clk64);
    check("t6_stay_idle", int'(busy), 0);
    arm = 1'b0;

    repeat (5) @(negedge clk64);
    check("queue_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
